// File: rtl/fast_kp_collector.sv
`timescale 1ns/1ps
// Keypoint collector: raster-tracks the NMS/orientation result stream, applies border mask and cap.
// Latency 1 cycle from accepted beat to o_valid; FWFT output FIFO, full FIFO drops and counts candidates.

module kp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  // Fullness is the registered count, so a same-cycle pop never frees room for a push.
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop_vld = (cnt_q != '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && pop_rdy;
  assign pop_dat = mem[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= push_dat;
  end
endmodule

module fast_kp_collector #(
  parameter int COORD_W    = 11,
  parameter int SCORE_W    = 8,
  parameter int ANG_W      = 12,
  parameter int FIFO_DEPTH = 64,
  parameter int KPC_W      = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_cfg_width,
  input  logic [COORD_W-1:0] i_cfg_height,
  input  logic [COORD_W-1:0] i_cfg_edge,
  input  logic [KPC_W-1:0]   i_cfg_max_kp,
  input  logic               i_valid,
  input  logic               i_flag,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [ANG_W-1:0]   i_cos,
  input  logic [ANG_W-1:0]   i_sin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [ANG_W-1:0]   o_cos,
  output logic [ANG_W-1:0]   o_sin,
  output logic               o_busy,
  output logic               o_done,
  output logic [KPC_W-1:0]   o_kp_count,
  output logic [KPC_W-1:0]   o_drop_count,
  output logic               o_capped
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SCORE_W-1:0] score;
    logic [ANG_W-1:0]   cosv;
    logic [ANG_W-1:0]   sinv;
  } kp_t;

  localparam int KP_W = $bits(kp_t);
  localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] w_q, h_q, border_q;
  logic [KPC_W-1:0]   max_kp_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [KPC_W-1:0]   kp_cnt_q, drop_cnt_q;
  logic               capped_q;

  logic beat, x_in, y_in, cand, at_cap, last_col, last_beat, push;
  logic fifo_full, fifo_vld;
  kp_t  push_kp, head_kp;

  // One extra bit keeps x+E from wrapping, so W<=2E / H<=2E mask everything.
  assign x_in = ({1'b0, x_q} >= {1'b0, border_q}) &&
                (({1'b0, x_q} + {1'b0, border_q}) < {1'b0, w_q});
  assign y_in = ({1'b0, y_q} >= {1'b0, border_q}) &&
                (({1'b0, y_q} + {1'b0, border_q}) < {1'b0, h_q});

  assign beat      = (state_q == ST_RUN) && i_valid;
  assign cand      = beat && i_flag && x_in && y_in;
  assign at_cap    = (kp_cnt_q == max_kp_q);
  assign push      = cand && !at_cap && !fifo_full;
  assign last_col  = (x_q == w_q - ONE_C);
  assign last_beat = last_col && (y_q == h_q - ONE_C);

  assign push_kp = '{x: x_q, y: y_q, score: i_score, cosv: i_cos, sinv: i_sin};

  kp_fifo #(.W(KP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push_vld (push),
    .push_dat (push_kp),
    .full     (fifo_full),
    .pop_vld  (fifo_vld),
    .pop_rdy  (i_ready),
    .pop_dat  (head_kp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_RUN;
      ST_RUN:   if (beat && last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (!fifo_vld) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_q        <= '0;
      h_q        <= '0;
      border_q   <= '0;
      max_kp_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      kp_cnt_q   <= '0;
      drop_cnt_q <= '0;
      capped_q   <= 1'b0;
    end else if (state_q == ST_IDLE && i_start) begin
      w_q        <= i_cfg_width;
      h_q        <= i_cfg_height;
      border_q   <= i_cfg_edge;
      max_kp_q   <= i_cfg_max_kp;
      x_q        <= '0;
      y_q        <= '0;
      kp_cnt_q   <= '0;
      drop_cnt_q <= '0;
      capped_q   <= 1'b0;
    end else if (beat) begin
      if (last_col) begin
        x_q <= '0;
        y_q <= y_q + ONE_C;
      end else begin
        x_q <= x_q + ONE_C;
      end
      // Cap check wins over the full check: a capped frame never counts drops.
      if (cand) begin
        if (at_cap)                capped_q   <= 1'b1;
        else if (fifo_full) begin
          if (drop_cnt_q != '1)    drop_cnt_q <= drop_cnt_q + KPC_W'(1);
        end else                   kp_cnt_q   <= kp_cnt_q + KPC_W'(1);
      end
    end
  end

  // DRAIN with an empty FIFO lasts exactly one cycle, which is the done pulse.
  assign o_done       = (state_q == ST_DRAIN) && !fifo_vld;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_valid      = fifo_vld;
  assign o_x          = fifo_vld ? head_kp.x     : '0;
  assign o_y          = fifo_vld ? head_kp.y     : '0;
  assign o_score      = fifo_vld ? head_kp.score : '0;
  assign o_cos        = fifo_vld ? head_kp.cosv  : '0;
  assign o_sin        = fifo_vld ? head_kp.sinv  : '0;
  assign o_kp_count   = kp_cnt_q;
  assign o_drop_count = drop_cnt_q;
  assign o_capped     = capped_q;
endmodule

// File: tb/tb_fast_kp_collector.sv
`timescale 1ns/1ps
// Directed frame table plus random-stall frame and mid-run reset for fast_kp_collector (FIFO depth 4).
module tb_fast_kp_collector;
  localparam int DEPTH = 4;

  logic        i_clk, i_rst_n, i_start, i_valid, i_flag, i_ready;
  logic [10:0] i_cfg_width, i_cfg_height, i_cfg_edge;
  logic [11:0] i_cfg_max_kp;
  logic [7:0]  i_score;
  logic [11:0] i_cos, i_sin;
  logic        o_valid, o_busy, o_done, o_capped;
  logic [10:0] o_x, o_y;
  logic [7:0]  o_score;
  logic [11:0] o_cos, o_sin, o_kp_count, o_drop_count;

  fast_kp_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height), .i_cfg_edge(i_cfg_edge),
    .i_cfg_max_kp(i_cfg_max_kp), .i_valid(i_valid), .i_flag(i_flag), .i_score(i_score),
    .i_cos(i_cos), .i_sin(i_sin), .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x),
    .o_y(o_y), .o_score(o_score), .o_cos(o_cos), .o_sin(o_sin), .o_busy(o_busy),
    .o_done(o_done), .o_kp_count(o_kp_count), .o_drop_count(o_drop_count), .o_capped(o_capped)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  sc;
    logic [11:0] c;
    logic [11:0] s;
  } kp_t;

  typedef struct {
    int w, h, e, m;
    int frand, vrand, rmode;
    int n, kp, drop, cap;
    int fx, fy, lx, ly;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_st, mx, my, mw, mh, me, mm;
  logic [11:0] mkp, mdrop;
  logic        mcap;
  kp_t         mq[$];
  kp_t         outs[$];

  task automatic check(input logic [81:0] a, input logic [81:0] e, input string nm);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
    end
  endtask

  function automatic logic [81:0] dut_vec();
    return {o_valid, o_x, o_y, o_score, o_cos, o_sin, o_busy, o_done,
            o_kp_count, o_drop_count, o_capped};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st = 0; mx = 0; my = 0; mw = 0; mh = 0; me = 0; mm = 0;
    mkp = '0; mdrop = '0; mcap = 1'b0;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic cyc();
    int   occ;
    bit   pop, push;
    kp_t  hd, nk;
    logic [81:0] expv;
    @(negedge i_clk);
    occ  = mq.size();
    hd   = (occ > 0) ? mq[0] : '0;
    expv = {occ > 0, hd, m_st != 0, (m_st == 2) && (occ == 0), mkp, mdrop, mcap};
    check(dut_vec(), expv, "cyc");
    if (o_valid && i_ready) outs.push_back({o_x, o_y, o_score, o_cos, o_sin});
    pop  = (occ > 0) && i_ready;
    push = 1'b0;
    nk   = '0;
    if (m_st == 1 && i_valid) begin
      if (i_flag && mx >= me && mx + me < mw && my >= me && my + me < mh) begin
        if (int'(mkp) == mm) mcap = 1'b1;
        else if (occ == DEPTH) begin
          if (mdrop != 12'hfff) mdrop++;
        end else begin
          push = 1'b1;
          nk   = {11'(mx), 11'(my), i_score, i_cos, i_sin};
          mkp++;
        end
      end
      if (mx == mw - 1 && my == mh - 1) m_st = 2;
      else if (mx == mw - 1) begin mx = 0; my++; end
      else mx++;
    end else if (m_st == 2 && occ == 0) begin
      m_st = 0;
    end else if (m_st == 0 && i_start) begin
      mw = int'(i_cfg_width); mh = int'(i_cfg_height); me = int'(i_cfg_edge);
      mm = int'(i_cfg_max_kp);
      mx = 0; my = 0; mkp = '0; mdrop = '0; mcap = 1'b0; m_st = 1;
    end
    if (pop)  hd = mq.pop_front();
    if (push) mq.push_back(nk);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    outs.delete();
    i_cfg_width  = 11'(v.w);
    i_cfg_height = 11'(v.h);
    i_cfg_edge   = 11'(v.e);
    i_cfg_max_kp = 12'(v.m);
    i_start = 1'b1;
    i_valid = 1'b1;
    i_ready = (v.rmode == 0);
    cyc();
    n = 0;
    while (m_st != 0 && n < 5000) begin
      i_start = 1'($urandom_range(0, 1));
      i_valid = (v.vrand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_flag  = (v.frand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_score = 8'($urandom);
      i_cos   = 12'($urandom);
      i_sin   = 12'($urandom);
      case (v.rmode)
        0:       i_ready = 1'b1;
        1:       i_ready = (m_st == 2);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      cyc();
      n++;
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    if (n >= 5000) begin
      bad++;
      total++;
      $display("FAIL timeout frame w=%0d h=%0d got=stuck want=idle", v.w, v.h);
    end
  endtask

  task automatic check_frame(input vec_t v);
    check(82'(outs.size()), 82'(v.n), "n_out");
    if (v.n > 0 && outs.size() > 0) begin
      check({71'(0), outs[0].x}, 82'(v.fx), "first_x");
      check({71'(0), outs[0].y}, 82'(v.fy), "first_y");
      check({71'(0), outs[outs.size()-1].x}, 82'(v.lx), "last_x");
      check({71'(0), outs[outs.size()-1].y}, 82'(v.ly), "last_y");
    end
    check({70'(0), o_kp_count},   82'(v.kp),   "kp_count");
    check({70'(0), o_drop_count}, 82'(v.drop), "drop_count");
    check({81'(0), o_capped},     82'(v.cap),  "capped");
  endtask

  vec_t vt[7];
  vec_t vr;

  initial begin
    //        w  h  e  m    fr vr rm  n   kp  drop cap fx fy lx ly
    vt[0] = '{8, 8, 2, 100, 0, 0, 0, 16, 16, 0,  0,  2, 2, 5, 5};
    vt[1] = '{8, 8, 2, 5,   0, 0, 0, 5,  5,  0,  1,  2, 2, 2, 3};
    vt[2] = '{8, 8, 0, 100, 0, 0, 1, 4,  4,  60, 0,  0, 0, 3, 0};
    vt[3] = '{6, 8, 3, 100, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0};
    vt[4] = '{4, 4, 0, 0,   0, 1, 0, 0,  0,  0,  1,  0, 0, 0, 0};
    vt[5] = '{5, 3, 1, 100, 0, 1, 2, 3,  3,  0,  0,  1, 1, 3, 1};
    vt[6] = '{4, 2, 0, 100, 0, 0, 0, 8,  8,  0,  0,  0, 0, 3, 1};

    i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_flag = 1'b0; i_ready = 1'b0;
    i_cfg_width = '0; i_cfg_height = '0; i_cfg_edge = '0; i_cfg_max_kp = '0;
    i_score = '0; i_cos = '0; i_sin = '0;
    model_reset();
    #22;
    check(dut_vec(), 82'(0), "reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i]);
      check_frame(vt[i]);
    end

    // Random stalls on both sides, random flags, 16x12 frame with border 3.
    vr = '{16, 12, 3, 100, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(vr);
    check({70'(0), o_kp_count}, 82'(outs.size()), "rand_kp_vs_out");
    check({70'(0), o_kp_count}, {70'(0), mkp}, "rand_kp");
    check({70'(0), o_drop_count}, {70'(0), mdrop}, "rand_drop");

    // Mid-frame reset with three entries queued.
    i_cfg_width = 11'd8; i_cfg_height = 11'd8; i_cfg_edge = 11'd0; i_cfg_max_kp = 12'd100;
    i_ready = 1'b0; i_start = 1'b1; i_valid = 1'b0;
    cyc();
    i_start = 1'b0; i_valid = 1'b1; i_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_score = 8'(k + 1);
      cyc();
    end
    i_valid = 1'b0;
    check({76'(0), o_valid, o_busy, o_kp_count[3:0]}, {76'(0), 1'b1, 1'b1, 4'd3}, "pre_rst");
    i_rst_n = 1'b0;
    #1;
    check(dut_vec(), 82'(0), "mid_rst");
    model_reset();
    @(posedge i_clk); #1;
    check(dut_vec(), 82'(0), "rst_hold");
    i_rst_n = 1'b1;
    cyc();
    run_frame(vt[6]);
    check_frame(vt[6]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fast_kp_collector.md
Name: fast_kp_collector

Overview:
- Back-end collector for the FAST/ORB detector pipeline. Sits after the NMS and orientation stages.
- Consumes the per-pixel result stream (flag, score, cos, sin) in raster order and tracks the raster coordinate of every accepted result.
- Applies a runtime-programmable border mask and keypoint cap, and queues surviving keypoints in an output FIFO with a valid/ready handshake.
- Successor to the fixed-size detector top: frame size, border and cap are configured per frame, and the result stream may stall.

Parameters:
COORD_W, 11, width of the coordinate and config dimension fields (frames up to 2047x2047)
SCORE_W, 8, FAST score width
ANG_W, 12, width of the cos/sin fields
FIFO_DEPTH, 64, keypoint FIFO entries; must be a power of two and >= 2
KPC_W, 12, width of the keypoint and drop counters and of i_cfg_max_kp

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse; sampled only in IDLE
i_cfg_width  in  COORD_W  frame width W; latched on i_start
i_cfg_height  in  COORD_W  frame height H; latched on i_start
i_cfg_edge  in  COORD_W  border margin E; latched on i_start
i_cfg_max_kp  in  KPC_W  keypoint cap M; latched on i_start
i_valid  in  1  one result beat present this cycle
i_flag  in  1  NMS keypoint flag
i_score  in  SCORE_W  NMS score
i_cos  in  ANG_W  orientation cosine
i_sin  in  ANG_W  orientation sine
o_valid  out  1  FIFO head valid
i_ready  in  1  downstream accepts the head
o_x  out  COORD_W  keypoint column
o_y  out  COORD_W  keypoint row
o_score  out  SCORE_W  keypoint score
o_cos  out  ANG_W  keypoint cosine
o_sin  out  ANG_W  keypoint sine
o_busy  out  1  high in RUN or DRAIN
o_done  out  1  one-cycle end-of-frame pulse
o_kp_count  out  KPC_W  keypoints pushed this frame
o_drop_count  out  KPC_W  candidates lost to a full FIFO
o_capped  out  1  keypoint cap reached this frame

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; x, y and both counters clear; the FIFO empties. All outputs are 0, including o_valid, o_done and o_capped.
- IDLE:
  - i_start=1 latches all four cfg inputs, clears x, y, o_kp_count, o_drop_count and o_capped, then moves to RUN.
  - i_valid is ignored in IDLE.
  - i_start is ignored in RUN and DRAIN.
- RUN:
  - Each i_valid=1 cycle is one raster position (x, y). The position then advances: x+1, or x=0 and y+1 when x==W-1.
  - Cycles with i_valid=0 advance nothing and push nothing.
- Candidate condition: i_flag && x>=E && x<W-E && y>=E && y<H-E.
  - Compare unsigned with one extra bit so that W<=2E or H<=2E produces no candidates. No wrap is allowed.
- Candidate handling (first matching rule applies):
  - o_kp_count==M: the candidate is discarded and o_capped goes to 1 and holds until the next i_start. M=0 therefore yields no keypoints.
  - FIFO full: o_drop_count increments, saturating at all-ones.
  - Otherwise: {x, y, score, cos, sin} is pushed and o_kp_count increments.
- Fullness is the registered occupancy. A pop in the same cycle does not free space for that cycle's push.
- The beat at (W-1, H-1) is processed as above, then the state moves to DRAIN.
- DRAIN: input is ignored. When the FIFO becomes empty, o_done pulses for 1 cycle the cycle after the last pop, and the state returns to IDLE.
- Counters and o_capped hold their values in IDLE until the next i_start.
- FIFO:
  - First-word-fall-through; o_valid = not empty.
  - A pop happens on o_valid && i_ready.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - Head data is stable while o_valid && !i_ready.
  - o_x..o_sin are driven to 0 whenever o_valid=0.
- Latency: a candidate pushed at clock edge N into an empty FIFO gives o_valid=1 after edge N (registered, 1 cycle).
- Order: keypoints leave in raster order, with no reordering and no duplication.

Test Plan:
- W=8, H=8, E=2, M=100; i_flag=1 on all 64 beats; i_ready=1 -> 16 keypoints with x,y in 2..5 in raster order, first (2,2); o_kp_count=16, o_done pulses once, o_capped=0.
- Same frame with M=5 -> exactly 5 outputs, last (2,3); o_capped=1, o_kp_count=5.
- FIFO_DEPTH=4, W=8, H=8, E=0, all flags set, i_ready=0 until DRAIN -> 4 keypoints (0,0)..(3,0) held; o_drop_count=60; after i_ready=1 the 4 drain, then o_done.
- Random i_valid gaps (50%) and random i_ready on a 16x12 frame, E=3, random flags -> output sequence equals the reference-model list; counters match.
- W=6, E=3 -> zero keypoints; o_done 1 cycle after the last input beat; o_kp_count=0.
- Reset asserted mid-RUN with 3 FIFO entries -> o_valid=0 and all outputs 0 immediately; a new i_start runs the next frame cleanly from (0,0).
